// File: rtl/rv_iopmp_match_sequencer.sv
// Scan controller for the IOPMP default decision logic: latches one transaction,
// walks the entry windows, and returns the first terminal verdict on a valid/ready channel.
module rv_iopmp_match_sequencer #(
  parameter int unsigned SID_WIDTH              = 8,
  parameter int unsigned NUMBER_ENTRIES         = 8,
  parameter int unsigned NUMBER_ENTRY_ANALYZERS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [SID_WIDTH-1:0] req_sid_i,
  input  logic [2:0]           req_access_i,
  output logic                 dl_enable_o,
  output logic [SID_WIDTH-1:0] dl_sid_o,
  output logic [2:0]           dl_access_o,
  output logic [8:0]           dl_entry_offset_o,
  input  logic                 dl_allow_i,
  input  logic                 dl_err_i,
  input  logic [2:0]           dl_err_type_i,
  input  logic [15:0]          dl_err_entry_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_allow_o,
  output logic                 rsp_err_o,
  output logic [2:0]           rsp_err_type_o,
  output logic [15:0]          rsp_err_entry_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [8:0] LAST_OFFSET = 9'(NUMBER_ENTRIES - NUMBER_ENTRY_ANALYZERS);
  localparam logic [8:0] OFFSET_STEP = 9'(NUMBER_ENTRY_ANALYZERS);

  state_e               state_q;
  logic [8:0]           offset_q;
  logic [SID_WIDTH-1:0] sid_q;
  logic [2:0]           access_q;
  logic                 en_q;
  logic                 dl_en_q;
  logic                 rsp_valid_q;
  logic                 rsp_allow_q;
  logic                 rsp_err_q;
  logic [2:0]           rsp_err_type_q;
  logic [15:0]          rsp_err_entry_q;
  logic                 terminal;

  // A disabled transaction needs no windows at all; the last window always terminates.
  assign terminal = dl_allow_i | dl_err_i | ~en_q | (offset_q == LAST_OFFSET);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      offset_q        <= '0;
      sid_q           <= '0;
      access_q        <= '0;
      en_q            <= 1'b0;
      dl_en_q         <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_allow_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_err_type_q  <= '0;
      rsp_err_entry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            sid_q    <= req_sid_i;
            access_q <= req_access_i;
            en_q     <= enable_i;
            dl_en_q  <= enable_i;
            offset_q <= '0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          if (terminal) begin
            // Error beats allow when the decision logic reports both.
            rsp_allow_q     <= dl_allow_i & ~dl_err_i & en_q;
            rsp_err_q       <= dl_err_i & en_q;
            rsp_err_type_q  <= en_q ? dl_err_type_i : 3'd0;
            rsp_err_entry_q <= en_q ? dl_err_entry_i : 16'd0;
            rsp_valid_q     <= 1'b1;
            dl_en_q         <= 1'b0;
            state_q         <= RESP;
          end else begin
            offset_q <= offset_q + OFFSET_STEP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            offset_q    <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o       = (state_q == IDLE);
  assign busy_o            = (state_q != IDLE);
  assign dl_enable_o       = dl_en_q;
  assign dl_sid_o          = sid_q;
  assign dl_access_o       = access_q;
  assign dl_entry_offset_o = offset_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_allow_o       = rsp_allow_q;
  assign rsp_err_o         = rsp_err_q;
  assign rsp_err_type_o    = rsp_err_type_q;
  assign rsp_err_entry_o   = rsp_err_entry_q;

endmodule

// File: tb/tb_rv_iopmp_match_sequencer.sv
// Directed bench for rv_iopmp_match_sequencer with a per-window decision-logic model.
module tb_rv_iopmp_match_sequencer;

  logic        clk;
  logic        rst_ni;
  logic        enable;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_sid;
  logic [2:0]  req_access;
  logic        dl_enable;
  logic [7:0]  dl_sid;
  logic [2:0]  dl_access;
  logic [8:0]  dl_offset;
  logic        dl_allow;
  logic        dl_err;
  logic [2:0]  dl_err_type;
  logic [15:0] dl_err_entry;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_allow;
  logic        rsp_err;
  logic [2:0]  rsp_err_type;
  logic [15:0] rsp_err_entry;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Decision-logic model: verdict per window (index 0 = offset 0, index 1 = offset 4).
  logic [1:0]  win_allow;
  logic [1:0]  win_err;
  logic [2:0]  win_type [2];
  logic [15:0] win_entry [2];
  logic        m_idx;

  int offs[$];

  rv_iopmp_match_sequencer #(
    .SID_WIDTH(8), .NUMBER_ENTRIES(8), .NUMBER_ENTRY_ANALYZERS(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_sid_i(req_sid), .req_access_i(req_access),
    .dl_enable_o(dl_enable), .dl_sid_o(dl_sid), .dl_access_o(dl_access),
    .dl_entry_offset_o(dl_offset),
    .dl_allow_i(dl_allow), .dl_err_i(dl_err),
    .dl_err_type_i(dl_err_type), .dl_err_entry_i(dl_err_entry),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_allow_o(rsp_allow), .rsp_err_o(rsp_err),
    .rsp_err_type_o(rsp_err_type), .rsp_err_entry_o(rsp_err_entry),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_idx = (dl_offset == 9'd4);
  always_comb begin
    dl_allow     = win_allow[m_idx];
    dl_err       = win_err[m_idx];
    dl_err_type  = win_type[m_idx];
    dl_err_entry = win_entry[m_idx];
  end

  task automatic set_windows(input logic [1:0] a, input logic [1:0] e,
                             input logic [2:0] t0, input logic [15:0] n0,
                             input logic [2:0] t1, input logic [15:0] n1);
    win_allow = a; win_err = e;
    win_type[0] = t0; win_entry[0] = n0;
    win_type[1] = t1; win_entry[1] = n1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of cycle 1.
  task automatic send_req(input logic [7:0] sid, input logic [2:0] acc,
                          input logic en, input logic en_after);
    req_sid = sid; req_access = acc; enable = en; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; enable = en_after;
  endtask

  // Walks scan cycles until rsp_valid; lat is the cycle number (accept = 0) it rose in.
  task automatic run_scan(output int lat, output logic en_all, output logic rdy_any);
    offs.delete();
    lat = 1; en_all = 1'b1; rdy_any = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      offs.push_back(int'(dl_offset));
      en_all  = en_all & dl_enable;
      rdy_any = rdy_any | req_ready;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({req_ready, busy, rsp_valid, dl_enable} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready/busy/valid/dlen=%b expected 1000",
               {req_ready, busy, rsp_valid, dl_enable});
    end
    tests_run++;
    if ({dl_offset, dl_sid, dl_access} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_dl: offset=%0d sid=%h access=%h expected 0/0/0",
               dl_offset, dl_sid, dl_access);
    end
    tests_run++;
    if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_entry} !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_rsp: allow=%b err=%b type=%h entry=%h expected all 0",
               rsp_allow, rsp_err, rsp_err_type, rsp_err_entry);
    end
  endtask

  task automatic test_allow_first();
    int lat; logic en_all, rdy_any;
    set_windows(2'b01, 2'b00, 3'h0, 16'h0, 3'h0, 16'h0);
    send_req(8'hA5, 3'h3, 1'b1, 1'b1);
    tests_run++;
    if ({dl_sid, dl_access} !== {8'hA5, 3'h3}) begin
      tests_failed++;
      $display("FAIL allow_latch: sid=%h access=%h expected a5/3", dl_sid, dl_access);
    end
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if (lat !== 2 || offs.size() !== 1 || offs[0] !== 0) begin
      tests_failed++;
      $display("FAIL allow_lat: latency=%0d windows=%0d expected 2/1 at offset 0", lat, offs.size());
    end
    tests_run++;
    if ({en_all, rdy_any} !== 2'b10) begin
      tests_failed++;
      $display("FAIL allow_scan_ctrl: dlen_all/ready_any=%b expected 10", {en_all, rdy_any});
    end
    tests_run++;
    if ({rsp_allow, rsp_err} !== 2'b10 || dl_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL allow_rsp: allow=%b err=%b dlen=%b expected 1/0/0", rsp_allow, rsp_err, dl_enable);
    end
    handshake();
    tests_run++;
    if ({req_ready, busy, rsp_valid} !== 3'b100 || dl_sid !== 8'hA5) begin
      tests_failed++;
      $display("FAIL allow_idle: ready/busy/valid=%b sid=%h expected 100/a5",
               {req_ready, busy, rsp_valid}, dl_sid);
    end
  endtask

  task automatic test_err_second();
    int lat; logic en_all, rdy_any;
    set_windows(2'b00, 2'b10, 3'h0, 16'h0, 3'h1, 16'd5);
    send_req(8'h11, 3'h1, 1'b1, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if (lat !== 3 || offs.size() !== 2 || offs[0] !== 0 || offs[1] !== 4) begin
      tests_failed++;
      $display("FAIL err2_lat: latency=%0d windows=%0d expected 3 with offsets 0,4", lat, offs.size());
    end
    tests_run++;
    if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_entry} !== {1'b0, 1'b1, 3'h1, 16'd5}) begin
      tests_failed++;
      $display("FAIL err2_rsp: allow=%b err=%b type=%h entry=%0d expected 0/1/1/5",
               rsp_allow, rsp_err, rsp_err_type, rsp_err_entry);
    end
    handshake();
  endtask

  task automatic test_no_wrap();
    int lat; logic en_all, rdy_any;
    set_windows(2'b00, 2'b10, 3'h0, 16'h0, 3'h5, 16'd7);
    send_req(8'h22, 3'h2, 1'b1, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if ({rsp_err, rsp_err_type} !== {1'b1, 3'h5} || dl_offset !== 9'd4 || lat !== 3) begin
      tests_failed++;
      $display("FAIL nowrap_err: err=%b type=%h offset=%0d latency=%0d expected 1/5/4/3",
               rsp_err, rsp_err_type, dl_offset, lat);
    end
    handshake();
    tests_run++;
    if (dl_offset !== 9'd0) begin
      tests_failed++;
      $display("FAIL nowrap_offset_clear: offset=%0d expected 0", dl_offset);
    end
    // No verdict anywhere: the last window still ends the scan, with an empty result.
    set_windows(2'b00, 2'b00, 3'h0, 16'h0, 3'h0, 16'h0);
    send_req(8'h33, 3'h4, 1'b1, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if (lat !== 3 || offs.size() !== 2 || {rsp_allow, rsp_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL last_window: latency=%0d windows=%0d allow=%b err=%b expected 3/2/0/0",
               lat, offs.size(), rsp_allow, rsp_err);
    end
    handshake();
  endtask

  task automatic test_err_wins();
    int lat; logic en_all, rdy_any;
    set_windows(2'b01, 2'b01, 3'h2, 16'd3, 3'h0, 16'h0);
    send_req(8'h44, 3'h1, 1'b1, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_entry} !== {1'b0, 1'b1, 3'h2, 16'd3} || lat !== 2) begin
      tests_failed++;
      $display("FAIL err_wins: allow=%b err=%b type=%h entry=%0d latency=%0d expected 0/1/2/3/2",
               rsp_allow, rsp_err, rsp_err_type, rsp_err_entry, lat);
    end
    handshake();
  endtask

  task automatic test_disabled();
    int lat; logic en_all, rdy_any;
    set_windows(2'b11, 2'b11, 3'h7, 16'hFFFF, 3'h7, 16'hFFFF);
    send_req(8'h55, 3'h3, 1'b0, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if (lat !== 2 || offs.size() !== 1 || en_all !== 1'b0) begin
      tests_failed++;
      $display("FAIL disabled_scan: latency=%0d windows=%0d dlen=%b expected 2/1/0",
               lat, offs.size(), en_all);
    end
    tests_run++;
    if ({rsp_allow, rsp_err, rsp_err_type, rsp_err_entry} !== 21'h0) begin
      tests_failed++;
      $display("FAIL disabled_rsp: allow=%b err=%b type=%h entry=%h expected all 0",
               rsp_allow, rsp_err, rsp_err_type, rsp_err_entry);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat; logic en_all, rdy_any;
    set_windows(2'b10, 2'b00, 3'h0, 16'h0, 3'h6, 16'd9);
    send_req(8'h66, 3'h2, 1'b1, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if (lat !== 3 || rsp_allow !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_first: latency=%0d allow=%b expected 3/1", lat, rsp_allow);
    end
    req_valid = 1'b1; req_sid = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({rsp_valid, req_ready, busy, rsp_allow, rsp_err, rsp_err_type, rsp_err_entry}
          !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'h6, 16'd9}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: valid=%b ready=%b busy=%b allow=%b err=%b type=%h entry=%0d expected 1/0/1/1/0/6/9",
                 i, rsp_valid, req_ready, busy, rsp_allow, rsp_err, rsp_err_type, rsp_err_entry);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests_run++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL bp_release: ready/busy/valid=%b expected 100", {req_ready, busy, rsp_valid});
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int lat; logic en_all, rdy_any;
    set_windows(2'b00, 2'b00, 3'h0, 16'h0, 3'h0, 16'h0);
    send_req(8'h88, 3'h5, 1'b1, 1'b1);
    @(posedge clk); #1;
    tests_run++;
    if (dl_offset !== 9'd4 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre: offset=%0d busy=%b expected 4/1", dl_offset, busy);
    end
    #1 rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({busy, rsp_valid, req_ready, dl_enable} !== 4'b0010 || dl_offset !== 9'd0 || dl_sid !== 8'h0) begin
      tests_failed++;
      $display("FAIL rst_async: busy/valid/ready/dlen=%b offset=%0d sid=%h expected 0010/0/00",
               {busy, rsp_valid, req_ready, dl_enable}, dl_offset, dl_sid);
    end
    #1 rst_ni = 1'b1;
    @(posedge clk); #1;
    set_windows(2'b01, 2'b00, 3'h0, 16'h0, 3'h0, 16'h0);
    send_req(8'h99, 3'h1, 1'b1, 1'b1);
    run_scan(lat, en_all, rdy_any);
    tests_run++;
    if (lat !== 2 || offs.size() !== 1 || offs[0] !== 0 || rsp_allow !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_restart: latency=%0d windows=%0d allow=%b expected 2/1/1",
               lat, offs.size(), rsp_allow);
    end
    handshake();
  endtask

  initial begin
    rst_ni = 1'b0; enable = 1'b0; req_valid = 1'b0; req_sid = '0;
    req_access = '0; rsp_ready = 1'b0;
    set_windows(2'b00, 2'b00, 3'h0, 16'h0, 3'h0, 16'h0);
    #12;
    test_reset();
    rst_ni = 1'b1;
    @(posedge clk); #1;
    test_allow_first();
    test_err_second();
    test_no_wrap();
    test_err_wins();
    test_disabled();
    test_back_to_back();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
